// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the BRAM read-port arbiter.
// Lock state encoding, requester id width and one-hot decode.
package mem_arb_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational picker: rotating priority from ptr, or lowest index
// when MEM_ARB_FIXED_PRIO_EN is defined. Only mask-enabled requests count.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] cand;

    assign cand = req & mask;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest set bit wins.
    always_comb begin
        grant = cand & (~cand + N_REQ'(1));
    end
`else
    logic [2*N_REQ-1:0] rot_dbl;
    logic [2*N_REQ-1:0] back_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   first;

    // Rotate so ptr sits at bit 0, take lowest set bit, rotate back.
    always_comb begin
        rot_dbl  = {cand, cand} >> ptr;
        rot      = rot_dbl[N_REQ-1:0];
        first    = rot & (~rot + N_REQ'(1));
        back_dbl = {first, first} << ptr;
        grant    = back_dbl[2*N_REQ-1:N_REQ];
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// One BRAM read port shared by N_REQ requesters, with burst lock and timeout.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1,
    parameter int LOCK_TO  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    bram_en,
    output logic [ADDR_W-1:0]       bram_addr,
    input  logic [DATA_W-1:0]       bram_dout,
    output logic                    busy
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = $clog2(LOCK_TO + 1);

    lock_state_e       state, state_n;
    logic [ID_W-1:0]   owner, owner_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic [N_REQ-1:0]  mask;
    logic [N_REQ-1:0]  grant;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [READ_LAT-1:0] pv;
    logic [ID_W-1:0]     pid [READ_LAT];

    // While locked only the owner may be picked.
    always_comb begin
        mask = '1;
        if (state == LOCKED) mask = N_REQ'(1) << owner;
    end

    rr_picker #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr),
        .mask (mask),
        .grant(grant)
    );

    assign accept    = rst & (|grant);
    assign win       = ID_W'(onehot_to_idx(MAX_REQ'(grant)));
    assign win_addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
    assign req_ready = rst ? grant : '0;
    assign bram_en   = accept;
    assign bram_addr = accept ? win_addr : last_addr;
    assign resp_data = bram_dout;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // Pointer moves just past the last winner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
        end
    end
`endif

    // Lock next-state: enter on a locked beat, leave on an unlocked owner beat or timeout.
    always_comb begin
        state_n = state;
        owner_n = owner;
        cnt_n   = cnt;
        unique case (state)
            UNLOCKED: begin
                if (accept && req_lock[win]) begin
                    state_n = LOCKED;
                    owner_n = win;
                    cnt_n   = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    cnt_n = '0;
                    if (!req_lock[win]) state_n = UNLOCKED;
                end else if (!req_valid[owner]) begin
                    if (cnt == CNT_W'(LOCK_TO - 1)) begin
                        state_n = UNLOCKED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Lock state, owner, timeout counter and last driven address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= UNLOCKED;
            owner     <= '0;
            cnt       <= '0;
            last_addr <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            if (accept) last_addr <= win_addr;
        end
    end

    // Response pipeline tracks which requester each in-flight read belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < READ_LAT; k++) begin
                pv[k]  <= 1'b0;
                pid[k] <= '0;
            end
        end else begin
            pv[0]  <= accept;
            pid[0] <= win;
            for (int k = 1; k < READ_LAT; k++) begin
                pv[k]  <= pv[k-1];
                pid[k] <= pid[k-1];
            end
        end
    end

    assign resp_valid = (rst && pv[READ_LAT-1]) ? N_REQ'(1) << pid[READ_LAT-1] : '0;
    assign busy       = rst & ((state == LOCKED) | (|pv));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one physical BRAM read port between N_REQ read requesters, by default the weight loader and the input loader feeding the MAC array.
- Arbitration is round-robin.
- A requester may lock the port for an uninterrupted burst.
- Each read response is returned to the issuing requester after a fixed READ_LAT cycles.
- Sits between the memory interface blocks and the single BRAM port.

Parameters:
N_REQ, 2, number of requesters (index 0 = weight path, 1 = input path)
ADDR_W, 8, BRAM address width ($clog2(MEM_DEPTH) with MEM_DEPTH=256)
DATA_W, 64, BRAM read data width (N_MACS*ACC_W)
READ_LAT, 1, BRAM cycles from bram_en to valid bram_dout (1..4)
LOCK_TO, 16, idle cycles after which a held lock is forcibly released (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
req_valid  in  N_REQ  read request per requester
req_lock  in  N_REQ  with an accepted request: keep ownership after this beat
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_ready  out  N_REQ  one-hot grant; request accepted when req_valid[i] & req_ready[i]
resp_valid  out  N_REQ  one-hot; read data for requester i valid this cycle
resp_data  out  DATA_W  read data, broadcast to all requesters
bram_en  out  1  BRAM read enable
bram_addr  out  ADDR_W  BRAM address
bram_dout  in  DATA_W  BRAM read data
busy  out  1  a lock is held or any read is in flight

Behaviour:
- Reset: sampled on posedge clk while rst==0.
  - Clears the rr pointer to 0, the lock, the lock owner and the timeout counter.
  - Flushes the response pipeline.
  - While rst==0, req_ready, bram_en, resp_valid and busy are forced to 0.
  - Reset mid-burst drops in-flight reads; no resp_valid follows.
- Arbitration (combinational, same cycle):
  - Unlocked: scan req_valid starting at rr pointer, wrapping modulo N_REQ; the first set bit wins.
  - Locked: only the owner may win; others see req_ready=0.
  - No valid request: req_ready=0, bram_en=0, bram_addr holds its last driven value.
- Issue: bram_en = |(req_valid & req_ready); bram_addr = req_addr of the winner. Zero added latency.
- Pointer: after any accepted beat, rr pointer <= winner+1 (wrap at N_REQ). Update is registered, effective next cycle.
- Lock state machine, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED on an accepted beat with req_lock=1; owner <= winner.
  - LOCKED -> UNLOCKED on an accepted owner beat with req_lock=0 (that beat is still serviced).
  - LOCKED -> UNLOCKED when the timeout counter reaches LOCK_TO.
  - Timeout counter: increments each LOCKED cycle with req_valid[owner]==0; resets to 0 on every owner beat and on release.
  - Timeout release takes effect the next cycle; others may win from then.
- Response pipeline:
  - READ_LAT-deep shift register of {valid, requester id}.
  - resp_valid[id] asserts exactly READ_LAT cycles after acceptance; resp_data = bram_dout that cycle.
  - Back-to-back beats yield back-to-back responses in issue order. No response backpressure.
- busy = LOCKED | any pipeline valid bit.
- Simultaneous release and competing request: the owner's final unlocked beat is granted; the competitor wins the next cycle via the rr pointer.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: unlocked arbitration is fixed priority, lowest index wins; the rr pointer is not implemented. Lock and timeout are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package/header mem_arb_pkg:
  - ID_W = $clog2(N_REQ) (min 1).
  - Lock state encoding: UNLOCKED=0, LOCKED=1.
  - Function onehot_to_idx.
- Sub-module rr_picker:
  - Combinational masked round-robin / fixed-priority picker.
  - Inputs: request vector, pointer, restrict mask. Output: one-hot grant.
  - Top level holds the pointer, lock FSM, timeout counter and response pipeline.

Test Plan:
1. Both requesters valid continuously, no lock, addr0=0x10, addr1=0x80 -> grants alternate 0,1,0,1; resp_valid toggles 01,10 one cycle later with matching dout.
2. Req0 issues 4 beats at 0x00..0x03 with lock=1,1,1,0 while req1 is valid -> req1 stalled 4 cycles, granted on 5th cycle; responses arrive in issue order.
3. Req1 locks at 0x20 then drops req_valid, LOCK_TO=16, req0 valid -> req0 first granted 17 cycles after the lock beat; busy=1 throughout the lock.
4. READ_LAT=3, single beat req0 at 0x05 -> resp_valid[0] exactly 3 cycles later; no other resp_valid pulses.
5. rst driven low for 1 cycle between issue and response -> no resp_valid; after reset, rr pointer=0 and req0 wins first contention.
6. With MEM_ARB_FIXED_PRIO_EN defined, both valid continuously -> req0 granted every cycle; req1 never granted.
